game_mmio_bridge: RTL and testbench
===================================

Name: game_mmio_bridge

Overview:
- Parametrised successor to the fixed two-player RAM/peripheral wrapper. Sits between the ARM data port and the data RAM, decoding a 16-word I/O window.
- Provides N players' paddle and score registers, debounced buttons with sticky edge capture, ball coordinates, and a frame counter with a pending flag.
- Read latency is 1 cycle for both RAM and I/O, so it is a drop-in on the processor's ReadData path.

Parameters:
- NUM_PLAYERS, 2, player count (1..6); buttons = 2*NUM_PLAYERS (up/down per player).
- ADDR_W, 16, word-address width.
- IO_BASE, 16'hFFF0, word address of the I/O window; must be 16-aligned.
- PADDLE_W, 8, paddle Y width.
- SCORE_W, 4, score width.
- DEBOUNCE_CYCLES, 4, stable cycles required before a debounced level changes (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- address  in  ADDR_W  word address from processor
- data  in  32  write data
- wren  in  1  write strobe
- rden  in  1  read strobe (qualifies clear-on-read)
- q  out  32  read data, valid 1 cycle after address/rden
- ram_address  out  ADDR_W  passthrough address to RAM
- ram_data  out  32  passthrough write data
- ram_wren  out  1  wren gated to the non-I/O region
- ram_q  in  32  RAM read data (1-cycle synchronous RAM)
- botones  in  2*NUM_PLAYERS  raw asynchronous buttons; bit 2p = player p up, bit 2p+1 = player p down
- frame_tick  in  1  one-cycle pulse per video frame
- paleta_y  out  NUM_PLAYERS*PADDLE_W  paddle Y, player p at [p*PADDLE_W +: PADDLE_W]
- puntaje  out  NUM_PLAYERS*SCORE_W  scores, packed like paleta_y
- bola_xy  out  32  ball coordinates {Y[15:0], X[15:0]}

Behaviour:
- Decode: io_sel = (address[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]). ram_wren = wren & ~io_sel. ram_address and ram_data always pass through.
- I/O map (offset = address[3:0]):
  - 0 BTN_LEVEL (RO): debounced levels, zero-extended.
  - 1 BTN_EDGE: sticky rising-edge flags. Clear-on-read when rden. Write-1-to-clear.
  - 2 BALL_XY (RW).
  - 3 FRAME (R): {pending, 15'b0, count[15:0]}. Any write clears pending; count is unaffected.
  - 4+p PADDLE[p] (RW, low PADDLE_W bits).
  - 4+NUM_PLAYERS+p SCORE[p] (RW, low SCORE_W bits; upper data bits ignored).
  - Unmapped offsets: read 0, writes ignored.
- Read path: sel and offset are registered on every cycle. The next cycle, q = sel_q ? io_rdata_q : ram_q. io_rdata_q is captured at the same edge, so latency is 1 for both paths. A write to a register is visible on a read issued the following cycle.
- Debounce (per button):
  - 2-flop synchroniser, then a counter.
  - When the synchronised value != level, the counter increments. When it reaches DEBOUNCE_CYCLES, level takes the new value and the counter resets.
  - A mismatch that disappears resets the counter.
  - Total latency from a stable raw change to level = 2 + DEBOUNCE_CYCLES cycles.
- Edge: a level 0->1 sets the edge bit. If set and clear (read or W1C) hit the same bit in the same cycle, set wins and the bit stays 1. Read data returns the pre-clear value.
- Frame: frame_tick increments count (wraps 16'hFFFF->0) and sets pending. If tick and FRAME write occur in the same cycle, pending = 1.
- Reset (asynchronous, active-low): all registers, counters, synchronisers, levels and edges go to 0. q=0, paleta_y=0, puntaje=0, bola_xy=0. ram_wren follows wren combinationally but is forced to 0 while reset is asserted. Reset mid-debounce discards progress.
- Outputs paleta_y, puntaje and bola_xy are direct register outputs, updated the cycle after the write.

Test Plan:
- Reset asserted mid-traffic -> all outputs 0 immediately (async). After release, read offset 0 -> q=0 one cycle later.
- Write 32'h0000_00A5 to IO_BASE+4, then read it back -> paleta_y[7:0]=8'hA5 next cycle, q=32'hA5. Write 32'hFF to IO_BASE+6 -> puntaje[3:0]=4'hF.
- Write 32'h1234_5678 to RAM address 16'h0010, read it back -> ram_wren=1 only on the write, q=32'h1234_5678 one cycle after the read. Write to IO_BASE+2 -> ram_wren=0, bola_xy=32'h1234_5678.
- botones[0] bounces 1,0,1 at 1-cycle intervals then holds 1 -> BTN_LEVEL bit0 rises exactly 2+4 cycles after the final stable edge. BTN_EDGE read -> 1, next read -> 0.
- BTN_EDGE read coinciding with a new rising edge on bit2 -> q shows the old value, bit2 remains 1 afterwards.
- 3 frame_tick pulses -> FRAME reads 32'h8000_0003. Write FRAME in the same cycle as a 4th tick -> reads 32'h8000_0004. Write alone -> 32'h0000_0004. Count at 16'hFFFF plus one tick -> count 0.

Source files
------------

// File: rtl/game_mmio_bridge.sv
// -----------------------------------------------------------------------------
// game_mmio_bridge
//
// Sits between the processor data port and the data RAM. Word addresses in the
// 16-word window at IO_BASE hit the game peripheral registers, and all other
// addresses go to the RAM. Both paths have a read latency of one cycle.
//
// I/O map (offset = address[3:0]):
//   0              BTN_LEVEL  RO  debounced button levels
//   1              BTN_EDGE   sticky rising edges; clear-on-read, write-1-to-clear
//   2              BALL_XY    RW  {Y[15:0], X[15:0]}
//   3              FRAME      R   {pending, 15'b0, count}; any write clears pending
//   4+p            PADDLE[p]  RW  low PADDLE_W bits
//   4+NUM_PLAYERS+p SCORE[p]  RW  low SCORE_W bits
//   others         read 0, writes ignored
//
// Ports:
//   clk, reset         system clock, asynchronous active-low reset
//   address/data       processor word address and write data
//   wren/rden          write strobe / read strobe (rden qualifies clear-on-read)
//   q                  read data, valid one cycle after address
//   ram_address/ram_data/ram_wren/ram_q   synchronous RAM interface
//   botones            raw buttons, bit 2p = player p up, bit 2p+1 = down
//   frame_tick         one-cycle pulse per video frame
//   paleta_y/puntaje   packed paddle Y and score registers, player p at p*W
//   bola_xy            ball coordinate register
// -----------------------------------------------------------------------------
module game_mmio_bridge #(
    parameter int unsigned       NUM_PLAYERS     = 2,
    parameter int unsigned       ADDR_W          = 16,
    parameter logic [ADDR_W-1:0] IO_BASE         = 16'hFFF0,
    parameter int unsigned       PADDLE_W        = 8,
    parameter int unsigned       SCORE_W         = 4,
    parameter int unsigned       DEBOUNCE_CYCLES = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [ADDR_W-1:0]               address,
    input  logic [31:0]                     data,
    input  logic                            wren,
    input  logic                            rden,
    output logic [31:0]                     q,
    output logic [ADDR_W-1:0]               ram_address,
    output logic [31:0]                     ram_data,
    output logic                            ram_wren,
    input  logic [31:0]                     ram_q,
    input  logic [2*NUM_PLAYERS-1:0]        botones,
    input  logic                            frame_tick,
    output logic [NUM_PLAYERS*PADDLE_W-1:0] paleta_y,
    output logic [NUM_PLAYERS*SCORE_W-1:0]  puntaje,
    output logic [31:0]                     bola_xy
);

    localparam int unsigned NB    = 2 * NUM_PLAYERS;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [3:0] OFF_LEVEL = 4'd0;
    localparam logic [3:0] OFF_EDGE  = 4'd1;
    localparam logic [3:0] OFF_BALL  = 4'd2;
    localparam logic [3:0] OFF_FRAME = 4'd3;

    // ---------------------------------------------------------------- decode
    logic       io_sel;
    logic [3:0] offset;
    logic       io_wr;
    logic       io_rd;

    assign io_sel      = (address[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]);
    assign offset      = address[3:0];
    assign io_wr       = wren & io_sel;
    assign io_rd       = rden & io_sel;
    assign ram_address = address;
    assign ram_data    = data;
    // The RAM must never see a write strobe while the system is held in reset.
    assign ram_wren    = wren & ~io_sel & reset;

    // ------------------------------------------------------------ registers
    logic [NB-1:0]       sync1_q, sync2_q;
    logic [NB-1:0]       level_q, level_d;
    logic [CNT_W-1:0]    cnt_q [NB];
    logic [CNT_W-1:0]    cnt_d [NB];
    logic [NB-1:0]       edge_flag_q, edge_flag_d;
    logic [NB-1:0]       rise, edge_clr;
    logic [31:0]         ball_q, ball_d;
    logic [PADDLE_W-1:0] paddle_q [NUM_PLAYERS];
    logic [PADDLE_W-1:0] paddle_d [NUM_PLAYERS];
    logic [SCORE_W-1:0]  score_q [NUM_PLAYERS];
    logic [SCORE_W-1:0]  score_d [NUM_PLAYERS];
    logic [15:0]         count_q, count_d;
    logic                pending_q, pending_d;
    logic                sel_q;
    logic [31:0]         io_rdata, io_rdata_q;

    // ------------------------------------------------------------ debounce
    // A level only moves after the synchronised input has disagreed with it
    // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        level_d = level_q;
        for (int b = 0; b < NB; b++) begin
            cnt_d[b] = '0;
            if (sync2_q[b] != level_q[b]) begin
                if (cnt_q[b] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_d[b] = sync2_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + CNT_W'(1);
                end
            end
        end
    end

    // ---------------------------------------------------------- edge flags
    // A new rising edge is OR-ed in after the clear, so a set landing in the
    // same cycle as a read or W1C survives.
    assign rise = level_d & ~level_q;

    always_comb begin
        edge_clr = '0;
        if (io_rd && offset == OFF_EDGE) begin
            edge_clr = '1;
        end
        if (io_wr && offset == OFF_EDGE) begin
            edge_clr = edge_clr | data[NB-1:0];
        end
        edge_flag_d = (edge_flag_q & ~edge_clr) | rise;
    end

    // --------------------------------------------------------------- frame
    // The tick is applied after the write-clear so a coincident tick wins.
    always_comb begin
        count_d   = count_q + {15'b0, frame_tick};
        pending_d = pending_q;
        if (io_wr && offset == OFF_FRAME) begin
            pending_d = 1'b0;
        end
        if (frame_tick) begin
            pending_d = 1'b1;
        end
    end

    // ------------------------------------------------------ game registers
    always_comb begin
        ball_d   = ball_q;
        paddle_d = paddle_q;
        score_d  = score_q;
        if (io_wr) begin
            if (offset == OFF_BALL) begin
                ball_d = data;
            end
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (offset == 4'(4 + p)) begin
                    paddle_d[p] = data[PADDLE_W-1:0];
                end
                if (offset == 4'(4 + NUM_PLAYERS + p)) begin
                    score_d[p] = data[SCORE_W-1:0];
                end
            end
        end
    end

    // ----------------------------------------------------------- read mux
    // Sampled from the current register values, so a read returns the state
    // before any clear or write happening in the same cycle.
    always_comb begin
        io_rdata = '0;
        case (offset)
            OFF_LEVEL: io_rdata = 32'(level_q);
            OFF_EDGE:  io_rdata = 32'(edge_flag_q);
            OFF_BALL:  io_rdata = ball_q;
            OFF_FRAME: io_rdata = {pending_q, 15'b0, count_q};
            default: begin
                for (int p = 0; p < NUM_PLAYERS; p++) begin
                    if (offset == 4'(4 + p)) begin
                        io_rdata = 32'(paddle_q[p]);
                    end
                    if (offset == 4'(4 + NUM_PLAYERS + p)) begin
                        io_rdata = 32'(score_q[p]);
                    end
                end
            end
        endcase
    end

    // -------------------------------------------------------- state update
    // NOTE: the handful of paddle/score/counter entries are ordinary flops,
    // not a RAM macro, so resetting them in a loop is cheap and required.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_q     <= '0;
            edge_flag_q <= '0;
            ball_q      <= '0;
            count_q     <= '0;
            pending_q   <= 1'b0;
            sel_q       <= 1'b0;
            io_rdata_q  <= '0;
            for (int b = 0; b < NB; b++) begin
                cnt_q[b] <= '0;
            end
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                paddle_q[p] <= '0;
                score_q[p]  <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of the others.
            sync1_q     <= botones;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            edge_flag_q <= edge_flag_d;
            ball_q      <= ball_d;
            paddle_q    <= paddle_d;
            score_q     <= score_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            sel_q       <= io_sel;
            io_rdata_q  <= io_rdata;
        end
    end

    // ------------------------------------------------------------ outputs
    always_comb begin
        paleta_y = '0;
        puntaje  = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            paleta_y[p*PADDLE_W +: PADDLE_W] = paddle_q[p];
            puntaje[p*SCORE_W +: SCORE_W]    = score_q[p];
        end
    end

    assign bola_xy = ball_q;
    // Forced low during reset because ram_q is not under reset control.
    assign q       = reset ? (sel_q ? io_rdata_q : ram_q) : 32'h0;

endmodule

// File: tb/tb_game_mmio_bridge.sv
// -----------------------------------------------------------------------------
// tb_game_mmio_bridge
//
// Self-checking bench for game_mmio_bridge with the default two-player
// configuration. A simple synchronous RAM sits on the RAM port, and a
// behavioural model of the register file (plain variables and an associative
// array for RAM contents) supplies every expected value.
// -----------------------------------------------------------------------------
module tb_game_mmio_bridge;

    localparam int          NP  = 2;
    localparam int          NB  = 2 * NP;
    localparam int          PW  = 8;
    localparam int          SW  = 4;
    localparam int          DEB = 4;
    localparam logic [15:0] IO_BASE = 16'hFFF0;

    logic              clk;
    logic              reset;
    logic [15:0]       address;
    logic [31:0]       data;
    logic              wren;
    logic              rden;
    logic [31:0]       q;
    logic [15:0]       ram_address;
    logic [31:0]       ram_data;
    logic              ram_wren;
    logic [31:0]       ram_q;
    logic [NB-1:0]     botones;
    logic              frame_tick;
    logic [NP*PW-1:0]  paleta_y;
    logic [NP*SW-1:0]  puntaje;
    logic [31:0]       bola_xy;

    int checks = 0;
    int passes = 0;

    // Reference model state
    logic [31:0]   ball_m;
    logic [PW-1:0] pad_m [NP];
    logic [SW-1:0] sc_m [NP];
    logic [15:0]   cnt_m;
    bit            pend_m;
    logic [NB-1:0] edge_m;
    logic [NB-1:0] lvl_m;
    logic [31:0]   ram_m [int];

    game_mmio_bridge #(
        .NUM_PLAYERS    (NP),
        .ADDR_W         (16),
        .IO_BASE        (IO_BASE),
        .PADDLE_W       (PW),
        .SCORE_W        (SW),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .data       (data),
        .wren       (wren),
        .rden       (rden),
        .q          (q),
        .ram_address(ram_address),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .ram_q      (ram_q),
        .botones    (botones),
        .frame_tick (frame_tick),
        .paleta_y   (paleta_y),
        .puntaje    (puntaje),
        .bola_xy    (bola_xy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM device on the RAM port (read-before-write).
    logic [31:0] ram_mem [256];
    initial begin
        for (int i = 0; i < 256; i++) ram_mem[i] = 32'h0;
        ram_q = 32'h0;
    end
    always @(posedge clk) begin
        if (ram_wren) ram_mem[ram_address[7:0]] <= ram_data;
        ram_q <= ram_mem[ram_address[7:0]];
    end

    // ------------------------------------------------------------ model
    function automatic void model_reset();
        ball_m = '0;
        for (int p = 0; p < NP; p++) begin
            pad_m[p] = '0;
            sc_m[p]  = '0;
        end
        cnt_m  = '0;
        pend_m = 1'b0;
        edge_m = '0;
        lvl_m  = '0;
    endfunction

    function automatic bit is_io(logic [15:0] a);
        return a[15:4] == IO_BASE[15:4];
    endfunction

    function automatic void model_write(logic [15:0] a, logic [31:0] d);
        int off;
        off = int'(a[3:0]);
        if (!is_io(a)) begin
            ram_m[int'(a)] = d;
        end else if (off == 1) begin
            edge_m = edge_m & ~d[NB-1:0];
        end else if (off == 2) begin
            ball_m = d;
        end else if (off == 3) begin
            pend_m = 1'b0;
        end else if (off >= 4 && off < 4 + NP) begin
            pad_m[off-4] = d[PW-1:0];
        end else if (off >= 4 + NP && off < 4 + 2 * NP) begin
            sc_m[off-4-NP] = d[SW-1:0];
        end
    endfunction

    function automatic logic [31:0] io_value(int off);
        if (off == 0) return 32'(lvl_m);
        if (off == 1) return 32'(edge_m);
        if (off == 2) return ball_m;
        if (off == 3) return {pend_m, 15'b0, cnt_m};
        if (off >= 4 && off < 4 + NP) return 32'(pad_m[off-4]);
        if (off >= 4 + NP && off < 4 + 2 * NP) return 32'(sc_m[off-4-NP]);
        return 32'h0;
    endfunction

    // Expected read data; reading BTN_EDGE clears the model flags afterwards.
    function automatic logic [31:0] model_read(logic [15:0] a);
        logic [31:0] r;
        if (!is_io(a)) begin
            r = ram_m.exists(int'(a)) ? ram_m[int'(a)] : 32'h0;
        end else begin
            r = io_value(int'(a[3:0]));
            if (a[3:0] == 4'd1) edge_m = '0;
        end
        return r;
    endfunction

    function automatic logic [NP*PW+NP*SW+31:0] model_outputs();
        logic [NP*PW-1:0] pp;
        logic [NP*SW-1:0] ss;
        for (int p = 0; p < NP; p++) begin
            pp[p*PW +: PW] = pad_m[p];
            ss[p*SW +: SW] = sc_m[p];
        end
        return {pp, ss, ball_m};
    endfunction

    // ------------------------------------------------------- bus helpers
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns the ram_wren seen while the write is presented.
    task automatic bus_write(input logic [15:0] a, input logic [31:0] d,
                             output logic rw);
        address = a;
        data    = d;
        wren    = 1'b1;
        rden    = 1'b0;
        #1 rw = ram_wren;
        @(posedge clk);
        #1;
        wren = 1'b0;
        model_write(a, d);
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [31:0] r);
        address = a;
        rden    = 1'b1;
        wren    = 1'b0;
        @(posedge clk);
        #1;
        rden = 1'b0;
        r    = q;
    endtask

    // --------------------------------------------------------------- tests
    task automatic test_reset();
        logic [31:0] r;
        logic        rw;
        reset = 1'b0; address = '0; data = '0; wren = 1'b0; rden = 1'b0;
        botones = '0; frame_tick = 1'b0;
        model_reset();
        #12 reset = 1'b1;
        @(posedge clk);
        #1;
        bus_write(IO_BASE + 16'd4, 32'h0000_003C, rw);
        bus_write(IO_BASE + 16'd2, 32'hCAFE_F00D, rw);
        bus_write(IO_BASE + 16'd6, 32'h0000_0005, rw);
        checks++;
        if ({paleta_y, puntaje, bola_xy} !== model_outputs())
            $display("FAIL pre_reset_outputs: got %h expected %h",
                     {paleta_y, puntaje, bola_xy}, model_outputs());
        else passes++;
        // Assert reset mid-cycle while a RAM write is being presented.
        address = 16'h0020; data = 32'h5555_AAAA; wren = 1'b1;
        #3 reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({paleta_y, puntaje, bola_xy} !== 56'h0)
            $display("FAIL reset_outputs: got %h expected 0", {paleta_y, puntaje, bola_xy});
        else passes++;
        checks++;
        if (q !== 32'h0) $display("FAIL reset_q: got %h expected 0", q);
        else passes++;
        checks++;
        if (ram_wren !== 1'b0) $display("FAIL reset_ram_wren: got %b expected 0", ram_wren);
        else passes++;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if (ram_wren !== 1'b1) $display("FAIL ram_wren_follows: got %b expected 1", ram_wren);
        else passes++;
        wren = 1'b0;
        @(posedge clk);
        #1;
        bus_read(IO_BASE, r);
        checks++;
        if (r !== 32'h0) $display("FAIL reset_read_level: got %h expected 0", r);
        else passes++;
        bus_read(IO_BASE + 16'd2, r);
        checks++;
        if (r !== 32'h0) $display("FAIL reset_read_ball: got %h expected 0", r);
        else passes++;
    endtask

    task automatic test_io_basic();
        logic [31:0] r;
        logic        rw;
        bus_write(IO_BASE + 16'd4, 32'h0000_00A5, rw);
        checks++;
        if (paleta_y[7:0] !== 8'hA5) $display("FAIL paddle0_out: got %h expected a5", paleta_y[7:0]);
        else passes++;
        bus_read(IO_BASE + 16'd4, r);
        checks++;
        if (r !== model_read(IO_BASE + 16'd4)) $display("FAIL paddle0_read: got %h expected 000000a5", r);
        else passes++;
        bus_write(IO_BASE + 16'd6, 32'h0000_00FF, rw);
        checks++;
        if (puntaje[3:0] !== 4'hF) $display("FAIL score0_out: got %h expected f", puntaje[3:0]);
        else passes++;
        bus_read(IO_BASE + 16'd6, r);
        checks++;
        if (r !== 32'h0000_000F) $display("FAIL score0_read: got %h expected 0000000f", r);
        else passes++;
    endtask

    task automatic test_ram();
        logic [31:0] r;
        logic        rw;
        bus_write(16'h0010, 32'h1234_5678, rw);
        checks++;
        if (rw !== 1'b1) $display("FAIL ram_write_strobe: got %b expected 1", rw);
        else passes++;
        address = 16'h0010; rden = 1'b1;
        #1;
        checks++;
        if (ram_wren !== 1'b0) $display("FAIL ram_read_strobe: got %b expected 0", ram_wren);
        else passes++;
        @(posedge clk);
        #1;
        rden = 1'b0;
        r = q;
        checks++;
        if (r !== model_read(16'h0010)) $display("FAIL ram_read: got %h expected 12345678", r);
        else passes++;
        bus_write(IO_BASE + 16'd2, 32'h1234_5678, rw);
        checks++;
        if (rw !== 1'b0) $display("FAIL io_write_strobe: got %b expected 0", rw);
        else passes++;
        checks++;
        if (bola_xy !== 32'h1234_5678) $display("FAIL ball_out: got %h expected 12345678", bola_xy);
        else passes++;
    endtask

    task automatic test_debounce();
        logic [31:0] r;
        address = IO_BASE; rden = 1'b0; wren = 1'b0;
        botones[0] = 1'b1; idle(1);
        botones[0] = 1'b0; idle(1);
        botones[0] = 1'b1;
        // Level rises 2+DEB cycles after the last change; the read adds one.
        for (int k = 1; k <= 3 + DEB + 1; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (q[0] !== (k >= 3 + DEB))
                $display("FAIL debounce_k%0d: got %b expected %b", k, q[0], (k >= 3 + DEB));
            else passes++;
        end
        lvl_m[0]  = 1'b1;
        edge_m[0] = 1'b1;
        bus_read(IO_BASE + 16'd1, r);
        checks++;
        if (r !== model_read(IO_BASE + 16'd1)) $display("FAIL edge_first_read: got %h expected 00000001", r);
        else passes++;
        bus_read(IO_BASE + 16'd1, r);
        checks++;
        if (r !== 32'h0) $display("FAIL edge_cleared: got %h expected 0", r);
        else passes++;
    endtask

    task automatic test_edge_collision();
        logic [31:0] r, e;
        logic        rw;
        botones[1] = 1'b1; idle(10);
        lvl_m[1] = 1'b1; edge_m[1] = 1'b1;
        // Time the BTN_EDGE read onto the edge where bit2's level rises.
        botones[2] = 1'b1;
        idle(1 + DEB);
        bus_read(IO_BASE + 16'd1, r);
        e = model_read(IO_BASE + 16'd1);
        lvl_m[2] = 1'b1; edge_m[2] = 1'b1;
        checks++;
        if (r !== e) $display("FAIL collision_old_value: got %h expected %h", r, e);
        else passes++;
        bus_read(IO_BASE + 16'd1, r);
        checks++;
        if (r !== 32'h0000_0004) $display("FAIL collision_set_wins: got %h expected 00000004", r);
        else passes++;
        edge_m = '0;
        // W1C of another bit leaves bit3 alone.
        botones[3] = 1'b1; idle(10);
        lvl_m[3] = 1'b1; edge_m[3] = 1'b1;
        bus_write(IO_BASE + 16'd1, 32'h0000_0001, rw);
        bus_read(IO_BASE + 16'd1, r);
        checks++;
        if (r !== 32'h0000_0008) $display("FAIL w1c_other_bit: got %h expected 00000008", r);
        else passes++;
        edge_m = '0;
        // Falling level sets nothing; a later rise cleared by W1C.
        botones[0] = 1'b0; idle(10);
        lvl_m[0] = 1'b0;
        bus_read(IO_BASE + 16'd1, r);
        e = model_read(IO_BASE + 16'd1);
        checks++;
        if (r !== e) $display("FAIL falling_no_edge: got %h expected %h", r, e);
        else passes++;
        bus_read(IO_BASE, r);
        checks++;
        if (r !== 32'(lvl_m)) $display("FAIL level_after_fall: got %h expected %h", r, 32'(lvl_m));
        else passes++;
        botones[0] = 1'b1; idle(10);
        lvl_m[0] = 1'b1; edge_m[0] = 1'b1;
        bus_write(IO_BASE + 16'd1, 32'h0000_0001, rw);
        bus_read(IO_BASE + 16'd1, r);
        e = model_read(IO_BASE + 16'd1);
        checks++;
        if (r !== e) $display("FAIL w1c_clears: got %h expected %h", r, e);
        else passes++;
    endtask

    task automatic test_random();
        logic [31:0] r, e, d;
        logic [15:0] a;
        logic        rw;
        logic [15:0] ram_addrs [$];
        for (int n = 0; n < 150; n++) begin
            int kind;
            kind = int'($urandom_range(0, 5));
            d    = $urandom;
            case (kind)
                0: a = IO_BASE + 16'(4 + $urandom_range(0, NP - 1));
                1: a = IO_BASE + 16'(4 + NP + $urandom_range(0, NP - 1));
                2: a = IO_BASE + 16'd2;
                3: a = 16'($urandom_range(0, 255));
                4: begin
                    int o;
                    o = int'($urandom_range(0, 10));
                    a = IO_BASE + ((o < 3) ? 16'(o == 2 ? 3 : o) : 16'(o + 5));
                end
                default: a = '0;
            endcase
            if (kind < 5) begin
                bus_write(a, d, rw);
                if (kind == 3) ram_addrs.push_back(a);
                checks++;
                if ({paleta_y, puntaje, bola_xy} !== model_outputs())
                    $display("FAIL rand_outputs_%0d: got %h expected %h", n,
                             {paleta_y, puntaje, bola_xy}, model_outputs());
                else passes++;
            end else begin
                if (ram_addrs.size() > 0 && $urandom_range(0, 2) == 0)
                    a = ram_addrs[$urandom_range(0, ram_addrs.size() - 1)];
                else
                    a = IO_BASE + 16'($urandom_range(0, 15));
                bus_read(a, r);
                e = model_read(a);
                checks++;
                if (r !== e) $display("FAIL rand_read_%0d addr %h: got %h expected %h", n, a, r, e);
                else passes++;
            end
        end
    endtask

    task automatic test_frame();
        logic [31:0] r, e;
        logic        rw;
        int          n;
        for (int i = 0; i < 3; i++) begin
            frame_tick = 1'b1; idle(1);
            frame_tick = 1'b0; idle(2);
            cnt_m++; pend_m = 1'b1;
        end
        bus_read(IO_BASE + 16'd3, r);
        checks++;
        if (r !== 32'h8000_0003) $display("FAIL frame_three_ticks: got %h expected 80000003", r);
        else passes++;
        frame_tick = 1'b1;
        bus_write(IO_BASE + 16'd3, 32'hFFFF_FFFF, rw);
        frame_tick = 1'b0;
        cnt_m++; pend_m = 1'b1;
        bus_read(IO_BASE + 16'd3, r);
        checks++;
        if (r !== 32'h8000_0004) $display("FAIL frame_tick_beats_write: got %h expected 80000004", r);
        else passes++;
        bus_write(IO_BASE + 16'd3, 32'h0, rw);
        bus_read(IO_BASE + 16'd3, r);
        checks++;
        if (r !== 32'h0000_0004) $display("FAIL frame_write_clears: got %h expected 00000004", r);
        else passes++;
        n = 16'hFFFF - int'(cnt_m);
        frame_tick = 1'b1;
        idle(n);
        frame_tick = 1'b0;
        cnt_m = 16'hFFFF; pend_m = 1'b1;
        bus_read(IO_BASE + 16'd3, r);
        e = model_read(IO_BASE + 16'd3);
        checks++;
        if (r !== e) $display("FAIL frame_at_max: got %h expected %h", r, e);
        else passes++;
        frame_tick = 1'b1; idle(1); frame_tick = 1'b0;
        cnt_m = cnt_m + 16'd1;
        bus_read(IO_BASE + 16'd3, r);
        checks++;
        if (r !== 32'h8000_0000) $display("FAIL frame_wrap: got %h expected 80000000", r);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_io_basic();
        test_ram();
        test_debounce();
        test_edge_collision();
        test_random();
        test_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
        $fatal(1);
    end

endmodule
